ctrl_fsm: RTL and testbench
===========================

CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 SHALL have parameter INSTRET_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have ports (one clock; reset asynchronous, active-low):
 clk  input  1  rising-edge clock
 rst_n  input  1  async active-low reset
 imem_valid  input  1  instr word valid this cycle
 instr  input  32  fetched instruction word
 zero  input  1  ALU result == 0, sampled in EXEC
 dmem_ready  input  1  data memory access complete
 imem_req  output  1  request next instruction
 pc_en  output  1  one-cycle IFU clock enable, instruction retire
 branch  output  1  resolved branch-taken, valid with pc_en
 jump  output  1  absolute jump, valid with pc_en
 jump_reg  output  1  jump to rs value (JR), valid with pc_en
 imm16  output  16  instr[15:0] of latched instruction
 targetInstr  output  26  instr[25:0] of latched instruction
 rs, rt  output  5 each  register-file read addresses
 reg_wr  output  1  register write strobe
 reg_wa  output  5  register write address
 wb_sel  output  2  00 ALU, 01 memory, 10 PC+4
 alu_op  output  3  000 ADD, 001 SUB, 010 XOR, 011 SLT
 alu_src_imm  output  1  ALU B = sign/zero-extended imm16
 dmem_rd, dmem_wr  output  1 each  data memory strobes
 illegal  output  1  sticky: unsupported opcode/funct seen
 state  output  3  current FSM state
 instret  output  INSTRET_W  retired-instruction count

Function
REQ-003 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-004 FETCH: imem_req=1; on imem_valid latch instr into internal IR, go DECODE; else stay.
REQ-005 imem_valid SHALL be ignored outside FETCH.
REQ-006 imm16, targetInstr, rs, rt SHALL be driven from IR, stable from DECODE until next FETCH latch.
REQ-007 Supported: R-type (op 0x00) funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08; LW 0x23, SW 0x2B, BNE 0x05, XORI 0x0E, J 0x02, JAL 0x03.
REQ-008 Paths: R-type ALU and XORI: FETCH-DECODE-EXEC-WB; LW: FETCH-DECODE-EXEC-MEM-WB; SW: FETCH-DECODE-EXEC-MEM; BNE, JR: FETCH-DECODE-EXEC; J: FETCH-DECODE; JAL: FETCH-DECODE-WB.
REQ-009 pc_en SHALL pulse exactly one cycle, in the last state of each path, then return to FETCH.
REQ-010 branch=1 only with pc_en for BNE when zero=0 in EXEC; BNE with zero=1 retires with branch=0.
REQ-011 jump=1 with pc_en for J and JAL; jump_reg=1 with pc_en for JR; branch/jump/jump_reg mutually exclusive, 0 otherwise.
REQ-012 WB: reg_wr=1 one cycle; reg_wa = rd (R-type), rt (LW, XORI), 31 (JAL); wb_sel 00/01/10 respectively.
REQ-013 alu_op/alu_src_imm valid in EXEC: ADD 000, SUB 001, SLT 011, XORI 010 with imm; LW/SW 000 with imm; BNE 001.
REQ-014 MEM: dmem_rd (LW) or dmem_wr (SW) held high until dmem_ready; exit on the cycle dmem_ready=1, no timeout.
REQ-015 Unsupported opcode/funct: set illegal (sticky until reset), retire as NOP from DECODE with pc_en, no strobes.
REQ-016 instret SHALL increment on every pc_en, wrapping modulo 2^INSTRET_W.

Reset
REQ-017 rst_n=0 SHALL immediately, independent of clk, force state=FETCH, IR=0, instret=0, illegal=0, and all strobes (pc_en, branch, jump, jump_reg, reg_wr, dmem_rd, dmem_wr) to 0.
REQ-018 Reset mid-instruction SHALL abandon it: no pc_en, no reg_wr, no dmem strobe after assertion; FETCH with imem_req=1 on first clk edge after deassertion.

Verification
REQ-019 ADD 0x00221820 -> pc_en in WB on cycle 4 after imem_valid cycle 1; reg_wr=1, reg_wa=3, wb_sel=00, alu_op=000; instret 0->1.
REQ-020 BNE 0x14220003, zero=0 in EXEC -> cycle 3 pc_en=1, branch=1, imm16=0x0003; repeat with zero=1 -> branch=0, pc_en=1.
REQ-021 J 0x08000008 -> cycle 2 pc_en=1, jump=1, targetInstr=26'd8; JAL 0x0C000008 -> cycle 3 reg_wr=1, reg_wa=31, wb_sel=10, jump=1.
REQ-022 LW 0x8C220004, dmem_ready low 3 cycles in MEM -> dmem_rd held 4 cycles, then WB reg_wa=2, wb_sel=01; total 8 cycles.
REQ-023 rst_n=0 during LW MEM state -> dmem_rd=0 and state=0 without clk edge; no reg_wr; instret unchanged at 0.
REQ-024 Opcode 0x3F -> illegal=1 and pc_en at DECODE; subsequent ADD retires normally, illegal stays 1; instret preloaded to all-ones wraps to 0.

Source files
------------

// File: rtl/ctrl_fsm.sv
// Multi-cycle control FSM for a small MIPS subset: latches one instruction word,
// walks it through FETCH/DECODE/EXEC/MEM/WB and retires it with a one-cycle pc_en.
module ctrl_fsm #(
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 imem_valid,
   input  logic [31:0]          instr,
   input  logic                 zero,
   input  logic                 dmem_ready,
   output logic                 imem_req,
   output logic                 pc_en,
   output logic                 branch,
   output logic                 jump,
   output logic                 jump_reg,
   output logic [15:0]          imm16,
   output logic [25:0]          targetInstr,
   output logic [4:0]           rs,
   output logic [4:0]           rt,
   output logic                 reg_wr,
   output logic [4:0]           reg_wa,
   output logic [1:0]           wb_sel,
   output logic [2:0]           alu_op,
   output logic                 alu_src_imm,
   output logic                 dmem_rd,
   output logic                 dmem_wr,
   output logic                 illegal,
   output logic [2:0]           state,
   output logic [INSTRET_W-1:0] instret
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_XOR = 3'b010;
   localparam logic [2:0] ALU_SLT = 3'b011;

   state_t                 state_q, state_d;
   logic [31:0]            ir;
   logic                   illegal_q;
   logic [INSTRET_W-1:0]   instret_q;

   // Decode is purely combinational from the latched IR, so every state sees it.
   logic [5:0] opcode, funct;
   logic       is_r, r_add, r_sub, r_slt, is_jr;
   logic       is_lw, is_sw, is_bne, is_xori, is_j, is_jal, supported;
   logic       unused_shamt;

   assign opcode    = ir[31:26];
   assign funct     = ir[5:0];
   assign is_r      = (opcode == 6'h00);
   assign r_add     = is_r && (funct == 6'h20);
   assign r_sub     = is_r && (funct == 6'h22);
   assign r_slt     = is_r && (funct == 6'h2A);
   assign is_jr     = is_r && (funct == 6'h08);
   assign is_lw     = (opcode == 6'h23);
   assign is_sw     = (opcode == 6'h2B);
   assign is_bne    = (opcode == 6'h05);
   assign is_xori   = (opcode == 6'h0E);
   assign is_j      = (opcode == 6'h02);
   assign is_jal    = (opcode == 6'h03);
   assign supported = r_add | r_sub | r_slt | is_jr | is_lw | is_sw |
                      is_bne | is_xori | is_j | is_jal;
   assign unused_shamt = ^ir[10:6];

   assign imm16       = ir[15:0];
   assign targetInstr = ir[25:0];
   assign rs          = ir[25:21];
   assign rt          = ir[20:16];
   assign state       = state_q;
   assign instret     = instret_q;
   // Flag is visible in the DECODE cycle that discovers it, then held by the register.
   assign illegal     = illegal_q | ((state_q == DECODE) && !supported);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         ir        <= 32'd0;
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == FETCH && imem_valid) ir <= instr;
         if (state_q == DECODE && !supported) illegal_q <= 1'b1;
         if (pc_en) instret_q <= instret_q + 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      imem_req    = 1'b0;
      pc_en       = 1'b0;
      branch      = 1'b0;
      jump        = 1'b0;
      jump_reg    = 1'b0;
      reg_wr      = 1'b0;
      reg_wa      = 5'd0;
      wb_sel      = 2'b00;
      alu_op      = ALU_ADD;
      alu_src_imm = 1'b0;
      dmem_rd     = 1'b0;
      dmem_wr     = 1'b0;
      unique case (state_q)
         FETCH: begin
            imem_req = 1'b1;
            if (imem_valid) state_d = DECODE;
         end
         DECODE: begin
            if (!supported) begin
               pc_en   = 1'b1;
               state_d = FETCH;
            end else if (is_j) begin
               pc_en   = 1'b1;
               jump    = 1'b1;
               state_d = FETCH;
            end else if (is_jal) begin
               state_d = WB;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            alu_src_imm = is_xori | is_lw | is_sw;
            if (r_sub || is_bne) alu_op = ALU_SUB;
            else if (r_slt)      alu_op = ALU_SLT;
            else if (is_xori)    alu_op = ALU_XOR;
            if (is_bne) begin
               pc_en   = 1'b1;
               branch  = !zero;
               state_d = FETCH;
            end else if (is_jr) begin
               pc_en    = 1'b1;
               jump_reg = 1'b1;
               state_d  = FETCH;
            end else if (is_lw || is_sw) begin
               state_d = MEM;
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            dmem_rd = is_lw;
            dmem_wr = is_sw;
            if (dmem_ready) begin
               if (is_lw) begin
                  state_d = WB;
               end else begin
                  pc_en   = 1'b1;
                  state_d = FETCH;
               end
            end
         end
         WB: begin
            reg_wr  = 1'b1;
            pc_en   = 1'b1;
            state_d = FETCH;
            if (is_jal) begin
               reg_wa = 5'd31;
               wb_sel = 2'b10;
               jump   = 1'b1;
            end else if (is_lw) begin
               reg_wa = ir[20:16];
               wb_sel = 2'b01;
            end else if (is_xori) begin
               reg_wa = ir[20:16];
            end else begin
               reg_wa = ir[15:11];
            end
         end
         default: state_d = FETCH;
      endcase
   end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Bench for ctrl_fsm: directed cases plus random instruction streams scored
// against a per-instruction transaction model (path length, strobes, retire flags).
module tb_ctrl_fsm;

   localparam int IW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          imem_valid;
   logic [31:0]   instr;
   logic          zero;
   logic          dmem_ready;
   logic          imem_req, pc_en, branch, jump, jump_reg;
   logic [15:0]   imm16;
   logic [25:0]   targetInstr;
   logic [4:0]    rs, rt, reg_wa;
   logic          reg_wr;
   logic [1:0]    wb_sel;
   logic [2:0]    alu_op;
   logic          alu_src_imm, dmem_rd, dmem_wr, illegal;
   logic [2:0]    state;
   logic [IW-1:0] instret;

   ctrl_fsm #(.INSTRET_W(IW)) dut (
      .clk(clk), .rst_n(rst_n), .imem_valid(imem_valid), .instr(instr),
      .zero(zero), .dmem_ready(dmem_ready), .imem_req(imem_req), .pc_en(pc_en),
      .branch(branch), .jump(jump), .jump_reg(jump_reg), .imm16(imm16),
      .targetInstr(targetInstr), .rs(rs), .rt(rt), .reg_wr(reg_wr),
      .reg_wa(reg_wa), .wb_sel(wb_sel), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
      .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .illegal(illegal), .state(state),
      .instret(instret)
   );

   always #5 clk = ~clk;

   typedef enum int {K_ALU, K_XORI, K_LW, K_SW, K_BNE, K_JR, K_J, K_JAL, K_ILL} kind_t;

   int            checks = 0;
   int            errors = 0;
   logic [IW-1:0] exp_instret;
   logic          exp_illegal;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic kind_t classify(input logic [31:0] w);
      kind_t k;
      case (w[31:26])
         6'h00: case (w[5:0])
                   6'h20, 6'h22, 6'h2A: k = K_ALU;
                   6'h08:               k = K_JR;
                   default:             k = K_ILL;
                endcase
         6'h23: k = K_LW;
         6'h2B: k = K_SW;
         6'h05: k = K_BNE;
         6'h0E: k = K_XORI;
         6'h02: k = K_J;
         6'h03: k = K_JAL;
         default: k = K_ILL;
      endcase
      return k;
   endfunction

   function automatic logic [31:0] gen_word();
      logic [31:0] w;
      logic [5:0]  op;
      w = $urandom;
      case ($urandom_range(0, 10))
         0: w[31:26] = 6'h00;
         1: begin w[31:26] = 6'h00; w[5:0] = 6'h20; end
         2: begin w[31:26] = 6'h00; w[5:0] = 6'h22; end
         3: begin w[31:26] = 6'h00; w[5:0] = 6'h2A; end
         4: begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
         5: w[31:26] = 6'h23;
         6: w[31:26] = 6'h2B;
         7: w[31:26] = 6'h05;
         8: w[31:26] = 6'h0E;
         9: w[31:26] = ($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03;
         default: begin
            op = 6'($urandom_range(1, 63));
            w[31:26] = op;
         end
      endcase
      return w;
   endfunction

   // Drive one instruction from FETCH to retirement and score it as a transaction.
   task automatic run_instr(input logic [31:0] w, input logic z, input int wait_n);
      kind_t      k;
      logic [2:0] exp_q[$];
      int         exp_len, cyc, mcnt, rd_cyc, wr_cyc, wr_cnt, stray;
      logic       retired, r_branch, r_jump, r_jreg, r_ill, a_imm;
      logic [2:0] a_op;
      logic [4:0] g_wa;
      logic [1:0] g_sel;
      logic [2:0] exp_op;
      logic [4:0] exp_wa;
      logic [1:0] exp_sel;
      logic [15:0] r_imm;
      logic [25:0] r_tgt;
      logic [4:0]  r_rs, r_rt;

      k = classify(w);
      exp_q.push_back(3'd0);
      exp_q.push_back(3'd1);
      case (k)
         K_ALU, K_XORI: begin exp_q.push_back(3'd2); exp_q.push_back(3'd4); end
         K_LW: begin
            exp_q.push_back(3'd2);
            for (int i = 0; i <= wait_n; i++) exp_q.push_back(3'd3);
            exp_q.push_back(3'd4);
         end
         K_SW: begin
            exp_q.push_back(3'd2);
            for (int i = 0; i <= wait_n; i++) exp_q.push_back(3'd3);
         end
         K_BNE, K_JR: exp_q.push_back(3'd2);
         K_JAL:       exp_q.push_back(3'd4);
         default: ;
      endcase
      exp_len = exp_q.size();

      cyc = 0; mcnt = 0; rd_cyc = 0; wr_cyc = 0; wr_cnt = 0; stray = 0; retired = 1'b0;
      r_branch = 0; r_jump = 0; r_jreg = 0; r_ill = 0; a_imm = 0; a_op = 0;
      g_wa = 0; g_sel = 0; r_imm = 0; r_tgt = 0; r_rs = 0; r_rt = 0;
      while (!retired && cyc < 30) begin
         @(negedge clk);
         cyc++;
         imem_valid = (cyc == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         instr      = (cyc == 1) ? w : $urandom;
         zero       = z;
         if (dmem_rd || dmem_wr) begin
            dmem_ready = (mcnt == wait_n);
            mcnt++;
         end else begin
            dmem_ready = 1'($urandom_range(0, 1));
         end
         #2;
         chk("state", 32'(state), 32'((exp_q.size() > 0) ? exp_q.pop_front() : 3'd7));
         if (cyc == 1) chk("imem_req", 32'(imem_req), 32'd1);
         if (dmem_rd) rd_cyc++;
         if (dmem_wr) wr_cyc++;
         if (reg_wr) begin wr_cnt++; g_wa = reg_wa; g_sel = wb_sel; end
         if (cyc == 3) begin a_op = alu_op; a_imm = alu_src_imm; end
         if (pc_en) begin
            retired = 1'b1;
            r_branch = branch; r_jump = jump; r_jreg = jump_reg; r_ill = illegal;
            r_imm = imm16; r_tgt = targetInstr; r_rs = rs; r_rt = rt;
         end else if (branch || jump || jump_reg) begin
            stray++;
         end
      end
      chk("retired", 32'(retired), 32'd1);
      chk("cycles", 32'(cyc), 32'(exp_len));
      chk("branch", 32'(r_branch), 32'(k == K_BNE && !z));
      chk("jump", 32'(r_jump), 32'(k == K_J || k == K_JAL));
      chk("jump_reg", 32'(r_jreg), 32'(k == K_JR));
      chk("stray_flags", 32'(stray), 32'd0);
      chk("dmem_rd_cycles", 32'(rd_cyc), 32'((k == K_LW) ? wait_n + 1 : 0));
      chk("dmem_wr_cycles", 32'(wr_cyc), 32'((k == K_SW) ? wait_n + 1 : 0));
      chk("reg_wr_count", 32'(wr_cnt),
          32'((k == K_ALU || k == K_XORI || k == K_LW || k == K_JAL) ? 1 : 0));
      if (wr_cnt == 1) begin
         exp_wa  = (k == K_JAL) ? 5'd31 : (k == K_ALU) ? w[15:11] : w[20:16];
         exp_sel = (k == K_JAL) ? 2'b10 : (k == K_LW) ? 2'b01 : 2'b00;
         chk("reg_wa", 32'(g_wa), 32'(exp_wa));
         chk("wb_sel", 32'(g_sel), 32'(exp_sel));
      end
      if (k inside {K_ALU, K_XORI, K_LW, K_SW, K_BNE}) begin
         case (k)
            K_ALU:   exp_op = (w[5:0] == 6'h22) ? 3'b001 : (w[5:0] == 6'h2A) ? 3'b011 : 3'b000;
            K_XORI:  exp_op = 3'b010;
            K_BNE:   exp_op = 3'b001;
            default: exp_op = 3'b000;
         endcase
         chk("alu_op", 32'(a_op), 32'(exp_op));
         chk("alu_src_imm", 32'(a_imm), 32'(k == K_XORI || k == K_LW || k == K_SW));
      end
      chk("imm16", 32'(r_imm), 32'(w[15:0]));
      chk("target", 32'(r_tgt), 32'(w[25:0]));
      chk("rs_rt", {22'd0, r_rs, r_rt}, {22'd0, w[25:21], w[20:16]});
      if (k == K_ILL) exp_illegal = 1'b1;
      chk("illegal", 32'(r_ill), 32'(exp_illegal));
      exp_instret = exp_instret + 1'b1;
      @(posedge clk);
      #1;
      chk("instret", 32'(instret), 32'(exp_instret));
      chk("back_to_fetch", 32'(state), 32'd0);
      imem_valid = 1'b0;
      dmem_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1; imem_valid = 1'b0; instr = 32'd0; zero = 1'b0; dmem_ready = 1'b0;
      exp_instret = '0; exp_illegal = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_instret", 32'(instret), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_strobes", {25'd0, pc_en, branch, jump, jump_reg, reg_wr, dmem_rd, dmem_wr}, 32'd0);
      chk("rst_imm16", 32'(imm16), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // Reset asserted while an LW waits in MEM, with no clock edge in between.
      @(negedge clk); imem_valid = 1'b1; instr = 32'h8C220004;
      @(negedge clk); imem_valid = 1'b0;
      @(negedge clk);
      @(negedge clk); #2;
      chk("lw_in_mem", 32'(dmem_rd), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_dmem_rd", 32'(dmem_rd), 32'd0);
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_reg_wr", 32'(reg_wr), 32'd0);
      chk("abort_instret", 32'(instret), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk); #2;
      chk("post_rst_state", 32'(state), 32'd0);
      chk("post_rst_imem_req", 32'(imem_req), 32'd1);

      run_instr(32'h00221820, 1'b0, 0);
      run_instr(32'h14220003, 1'b0, 0);
      run_instr(32'h14220003, 1'b1, 0);
      run_instr(32'h08000008, 1'b0, 0);
      run_instr(32'h0C000008, 1'b0, 0);
      run_instr(32'h8C220004, 1'b0, 3);
      run_instr(32'hAC450010, 1'b0, 2);
      run_instr(32'h0022000E, 1'b0, 0);
      run_instr(32'h03E00008, 1'b0, 0);
      run_instr(32'hFC000000, 1'b0, 0);
      run_instr(32'h00221820, 1'b0, 0);

      for (int n = 0; n < 120; n++)
         run_instr(gen_word(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));

      // Counter wrap: advance to all ones, then retire an unsupported opcode.
      for (int n = 0; n < 40 && exp_instret != '1; n++)
         run_instr(gen_word(), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      chk("instret_all_ones", 32'(instret), 32'(IW'('1)));
      run_instr(32'hFC000000, 1'b0, 0);
      chk("instret_wrap", 32'(instret), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
